apb_reg_slave: RTL
==================

Name: apb_reg_slave

Overview:
- APB completer (slave) that terminates the bus driven by the system APB master.
- Provides NUM_REGS word-wide registers: a read-only ID at index 0 and read/write scratch/control registers at indices 1..NUM_REGS-1.
- Inserts a parameterised number of wait states and signals error responses on slave_error.
- Serves as both a real peripheral and the reference responder for master-side verification.

Parameters:
ADDR_WIDTH, 32, width of addr.
DATA_WIDTH, 32, width of wdata/rdata (multiple of 8).
NUM_REGS, 8, number of registers (power of two, 2..256).
WAIT_CYCLES, 0, wait states inserted in every access phase (0..15).
ID_VALUE, 32'hA9B0_0001, constant returned by register 0.

Ports:
clk  input  1  bus clock; all logic on rising edge
rstn  input  1  asynchronous reset, active-high (1 = reset asserted)
sel  input  1  slave select
penable  input  1  access-phase indicator
write  input  1  1 = write, 0 = read
addr  input  ADDR_WIDTH  byte address
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data, valid when ready=1 and write=0
ready  output  1  transfer completes this cycle
slave_error  output  1  error response, valid only when ready=1

Behaviour:
- Reset (rstn=1, asynchronous): state=IDLE; ready=0; slave_error=0; rdata=0; wait counter=0; registers 1..NUM_REGS-1 = 0.
- Setup detect: sel=1 and penable=0 while in IDLE.
  - Latch addr, write and wdata.
  - Decode error: err = (addr[1:0]!=0) | (addr >= NUM_REGS*4) | (write & index==0).
  - index = addr[2 +: log2(NUM_REGS)].
- States:
  - IDLE: on setup detect, go to RESP with ready<=1 if WAIT_CYCLES==0. Otherwise go to WAIT with counter<=WAIT_CYCLES-1.
  - WAIT: ready=0. If sel=0, abort to IDLE with no side effect. Else if counter==0, go to RESP with ready<=1. Else decrement the counter.
  - RESP: ready=1 for exactly one cycle. Commit happens on this edge if sel=1 and penable=1. Next state is IDLE with ready<=0.
- Timing: setup in cycle T means ready=1 in cycle T+1+WAIT_CYCLES.
- Read response: rdata and slave_error are registered so they are valid during the ready=1 cycle.
  - rdata = ID_VALUE for index 0, reg[index] otherwise.
  - rdata = 0 when err=1.
  - rdata is held at its last value outside response cycles.
- Write commit: reg[index] <= latched wdata at the end of the RESP cycle when err=0. When err=1 the write is suppressed, slave_error=1 and the registers are unchanged.
- Back-to-back: a setup phase in the cycle immediately after RESP is accepted normally. Minimum transfer length is 2 cycles.
- If sel/penable are not asserted during RESP (master violation), the transfer is dropped: no write, return to IDLE.
- slave_error is 0 whenever ready=0.
- Reset asserted mid-transfer: immediate return to IDLE, ready=0, no partial write. Registers return to 0.
- Wait counter width: 4 bits. WAIT_CYCLES > 15 is illegal and must be caught by an elaboration-time check.

Optional Feature:
- APB_SLV_WSTRB_EN defined:
  - Adds input strb, width DATA_WIDTH/8.
  - On write commit, byte lane i of reg[index] is updated only when strb[i]=1.
  - strb=0 on a write is a legal no-op with slave_error=0.
  - strb is ignored for reads.
- Undefined: no strb port; every write updates the full word.

Test Plan:
- Reset, then read addr 0x0 with WAIT_CYCLES=0 -> ready at T+1, rdata=32'hA9B0_0001, slave_error=0. Read 0x4 -> rdata=0.
- Write 0xDEAD_BEEF to 0x8, then read 0x8 -> write completes with slave_error=0; read returns 0xDEAD_BEEF.
- WAIT_CYCLES=3, write 0x1234_5678 to 0xC -> ready low for cycles T+1..T+3 and high only at T+4; a readback of 0xC returns 0x1234_5678.
- Error cases -> ready with slave_error=1 and registers unchanged in each case:
  - write to 0x0;
  - read of 0x20 with NUM_REGS=8 (rdata=0);
  - write to 0x6.
- Abort and reset mid-transfer:
  - WAIT_CYCLES=2, drop sel during WAIT after setup to 0x4 with data 0xFF -> ready never asserts and reg1 remains 0.
  - Assert rstn mid-WAIT -> ready=0 within the same cycle.
- APB_SLV_WSTRB_EN defined: reg2=0x1122_3344, write 0xAABB_CCDD with strb=4'b0101 -> read returns 0x11BB_33DD.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a read-only ID register, NUM_REGS-1 R/W registers
// and WAIT_CYCLES wait states. Define APB_SLV_WSTRB_EN to add byte-lane write strobes.
module apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel,
    input  logic                    penable,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef APB_SLV_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] strb,
`endif
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    slave_error
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("apb_reg_slave: WAIT_CYCLES must be in 0..15");
    end
    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
        $error("apb_reg_slave: NUM_REGS must be a power of two in 2..256");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("apb_reg_slave: DATA_WIDTH must be a multiple of 8");
    end

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_ready;
    logic                  r_slv_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
`ifdef APB_SLV_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] r_strb;
`endif
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_setup;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rd_new;
    logic [DATA_WIDTH-1:0] w_rd_lat;

    // Anything at or above NUM_REGS*4 has a nonzero bit above the index field.
    assign w_setup  = sel & ~penable;
    assign w_idx    = addr[2 +: IDX_W];
    assign w_err    = (addr[1:0] != 2'b00) | ((addr >> (IDX_W + 2)) != '0) |
                      (write & (w_idx == '0));
    assign w_rd_new = w_err ? '0 : (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
    assign w_rd_lat = r_err ? '0 : (r_idx == '0) ? ID_VALUE : r_regs[r_idx];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_slv_err <= 1'b0;
            r_rdata   <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= '0;
`ifdef APB_SLV_WSTRB_EN
            r_strb    <= '0;
`endif
            // NOTE: the register file is flops, not RAM, so it is cleared by reset like any other state.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_idx   <= w_idx;
                        r_write <= write;
                        r_err   <= w_err;
                        r_wdata <= wdata;
`ifdef APB_SLV_WSTRB_EN
                        r_strb  <= strb;
`endif
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= S_RESP;
                            r_ready   <= 1'b1;
                            r_slv_err <= w_err;
                            if (!write) r_rdata <= w_rd_new;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!sel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state   <= S_RESP;
                        r_ready   <= 1'b1;
                        r_slv_err <= r_err;
                        if (!r_write) r_rdata <= w_rd_lat;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b0;
                    r_slv_err <= 1'b0;
                    // A master that drops sel/penable here abandons the write.
                    if (sel && penable && r_write && !r_err) begin
`ifdef APB_SLV_WSTRB_EN
                        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                            if (r_strb[b]) r_regs[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                        end
`else
                        r_regs[r_idx] <= r_wdata;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign ready       = r_ready;
    assign slave_error = r_slv_err;

endmodule
